// File: rtl/alu_issue_if.sv
// Purpose: bundle of the decode->issue handshake, the operand bypass buses and the issue->ALU outputs.
// Latency: none. This file holds wiring only.
// Backpressure: dec_ready/iss_ready carry the valid/ready handshake on each side.
// Ports: master = decode/forwarding/ALU environment, slave = alu_issue_stage.
interface alu_issue_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    // decode side
    logic                 dec_valid;
    logic                 dec_ready;
    logic [XLEN-1:0]      dec_pc;
    logic [REG_IDX_W-1:0] dec_rs1_idx;
    logic [REG_IDX_W-1:0] dec_rs2_idx;
    logic [XLEN-1:0]      dec_rs1_data;
    logic [XLEN-1:0]      dec_rs2_data;
    logic [XLEN-1:0]      dec_imm;
    logic [2:0]           dec_funct3;
    logic                 dec_funct7_5;
    logic                 dec_op_imm;
    logic                 dec_force_add;
    logic                 dec_a_pc;
    logic [REG_IDX_W-1:0] dec_rd;
    logic                 dec_reg_write;
    logic                 flush;

    // result bypass from EX/MEM and MEM/WB
    logic                 ex_fwd_en;
    logic [REG_IDX_W-1:0] ex_fwd_rd;
    logic [XLEN-1:0]      ex_fwd_data;
    logic                 wb_fwd_en;
    logic [REG_IDX_W-1:0] wb_fwd_rd;
    logic [XLEN-1:0]      wb_fwd_data;

    // issue side
    logic                 iss_valid;
    logic                 iss_ready;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [3:0]           alu_control;
    logic [XLEN-1:0]      iss_rs2_val;
    logic [REG_IDX_W-1:0] iss_rd;
    logic                 iss_reg_write;

    modport master (
        output dec_valid, dec_pc, dec_rs1_idx, dec_rs2_idx, dec_rs1_data, dec_rs2_data,
               dec_imm, dec_funct3, dec_funct7_5, dec_op_imm, dec_force_add, dec_a_pc,
               dec_rd, dec_reg_write, flush,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
               iss_ready,
        input  dec_ready, iss_valid, alu_a, alu_b, alu_control, iss_rs2_val, iss_rd,
               iss_reg_write
    );

    modport slave (
        input  dec_valid, dec_pc, dec_rs1_idx, dec_rs2_idx, dec_rs1_data, dec_rs2_data,
               dec_imm, dec_funct3, dec_funct7_5, dec_op_imm, dec_force_add, dec_a_pc,
               dec_rd, dec_reg_write, flush,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
               iss_ready,
        output dec_ready, iss_valid, alu_a, alu_b, alu_control, iss_rs2_val, iss_rd,
               iss_reg_write
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Purpose: ID->EX register stage feeding the ALU: holds one instruction, forwards results, builds operands and control.
// Latency: 1 cycle from decode accept to valid ALU inputs, full throughput.
// Backpressure: dec_ready = !iss_valid | iss_ready; while stalled the held instruction stays put and its data keeps refreshing from WB.
// Ports: clk, rst_n (synchronous, active low), io (alu_issue_if.slave: decode bus, flush, EX/WB bypass, issue/ALU outputs).
module alu_issue_stage #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  io
);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rs1_idx;
        logic [REG_IDX_W-1:0] rs2_idx;
        logic [REG_IDX_W-1:0] rd;
        logic [2:0]           funct3;
        logic                 funct7_5;
        logic                 op_imm;
        logic                 force_add;
        logic                 a_pc;
        logic                 reg_write;
    } hdr_t;

    hdr_t held_q;
    hdr_t held_d;
    logic valid_q;
    logic valid_d;
    logic dec_ready;
    logic accept;

    // A bypass source only matches a real register; x0 is never forwarded.
    function automatic logic fwd_match(
        input logic                 en,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] idx
    );
        return en && (rd == idx) && (idx != '0);
    endfunction

    assign dec_ready    = !valid_q || io.iss_ready;
    assign accept       = io.dec_valid && dec_ready && !io.flush;
    assign io.dec_ready = dec_ready;

    // Next-state for the held instruction.
    always_comb begin
        held_d  = held_q;
        valid_d = valid_q;

        if (io.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d            = 1'b1;
            held_d.pc          = io.dec_pc;
            held_d.rs1_idx     = io.dec_rs1_idx;
            held_d.rs2_idx     = io.dec_rs2_idx;
            held_d.imm         = io.dec_imm;
            held_d.funct3      = io.dec_funct3;
            held_d.funct7_5    = io.dec_funct7_5;
            held_d.op_imm      = io.dec_op_imm;
            held_d.force_add   = io.dec_force_add;
            held_d.a_pc        = io.dec_a_pc;
            held_d.rd          = io.dec_rd;
            held_d.reg_write   = io.dec_reg_write;
            // The regfile read happened before the WB write landed, so take the
            // WB value directly. EX is not captured: it is still live next cycle
            // and gets picked up by the output mux.
            held_d.rs1_data = fwd_match(io.wb_fwd_en, io.wb_fwd_rd, io.dec_rs1_idx)
                            ? io.wb_fwd_data : io.dec_rs1_data;
            held_d.rs2_data = fwd_match(io.wb_fwd_en, io.wb_fwd_rd, io.dec_rs2_idx)
                            ? io.wb_fwd_data : io.dec_rs2_data;
        end else if (valid_q && io.iss_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: a WB result retiring now would otherwise be lost once it
            // leaves the bypass bus, so fold it into the held copy.
            if (fwd_match(io.wb_fwd_en, io.wb_fwd_rd, held_q.rs1_idx)) begin
                held_d.rs1_data = io.wb_fwd_data;
            end
            if (fwd_match(io.wb_fwd_en, io.wb_fwd_rd, held_q.rs2_idx)) begin
                held_d.rs2_data = io.wb_fwd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    // Operand forwarding and ALU control, all combinational from held state.
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            f7;

    always_comb begin
        rs1_fwd = held_q.rs1_data;
        if (fwd_match(io.ex_fwd_en, io.ex_fwd_rd, held_q.rs1_idx)) begin
            rs1_fwd = io.ex_fwd_data;
        end else if (fwd_match(io.wb_fwd_en, io.wb_fwd_rd, held_q.rs1_idx)) begin
            rs1_fwd = io.wb_fwd_data;
        end

        rs2_fwd = held_q.rs2_data;
        if (fwd_match(io.ex_fwd_en, io.ex_fwd_rd, held_q.rs2_idx)) begin
            rs2_fwd = io.ex_fwd_data;
        end else if (fwd_match(io.wb_fwd_en, io.wb_fwd_rd, held_q.rs2_idx)) begin
            rs2_fwd = io.wb_fwd_data;
        end

        // For OP-IMM bit 30 is part of the immediate except on SRAI, so only
        // funct3=101 may turn it into the alternate-op flag.
        f7 = held_q.op_imm ? ((held_q.funct3 == 3'b101) && held_q.funct7_5)
                           : held_q.funct7_5;
    end

    assign io.iss_valid     = valid_q;
    assign io.alu_a         = held_q.a_pc ? held_q.pc : rs1_fwd;
    assign io.alu_b         = (held_q.op_imm || held_q.force_add) ? held_q.imm : rs2_fwd;
    assign io.alu_control   = held_q.force_add ? 4'b0000
                                               : {f7 | held_q.funct3[1], held_q.funct3};
    assign io.iss_rs2_val   = rs2_fwd;
    assign io.iss_rd        = held_q.rd;
    assign io.iss_reg_write = held_q.reg_write && valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(XLEN), .REG_IDX_W(RW)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_valid = 0; bus.dec_pc = 0; bus.dec_rs1_idx = 0; bus.dec_rs2_idx = 0;
        bus.dec_rs1_data = 0; bus.dec_rs2_data = 0; bus.dec_imm = 0; bus.dec_funct3 = 0;
        bus.dec_funct7_5 = 0; bus.dec_op_imm = 0; bus.dec_force_add = 0; bus.dec_a_pc = 0;
        bus.dec_rd = 0; bus.dec_reg_write = 0; bus.flush = 0;
        bus.ex_fwd_en = 0; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 0;
        bus.wb_fwd_en = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
        bus.iss_ready = 1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [2:0] f3, input logic f75, input logic opimm,
                           input logic fadd, input logic apc, input logic [4:0] rd,
                           input logic rw);
        bus.dec_valid = 1; bus.dec_pc = pc; bus.dec_rs1_idx = rs1; bus.dec_rs2_idx = rs2;
        bus.dec_rs1_data = d1; bus.dec_rs2_data = d2; bus.dec_imm = imm; bus.dec_funct3 = f3;
        bus.dec_funct7_5 = f75; bus.dec_op_imm = opimm; bus.dec_force_add = fadd;
        bus.dec_a_pc = apc; bus.dec_rd = rd; bus.dec_reg_write = rw;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.iss_valid); end
        checks++; if (bus.alu_a !== 32'd0) begin failures++; $display("FAIL rst_alu_a got=%h exp=0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd0) begin failures++; $display("FAIL rst_alu_b got=%h exp=0", bus.alu_b); end
        checks++; if (bus.alu_control !== 4'b0000) begin failures++; $display("FAIL rst_ctrl got=%b exp=0000", bus.alu_control); end
        checks++; if (bus.iss_rs2_val !== 32'd0) begin failures++; $display("FAIL rst_rs2 got=%h exp=0", bus.iss_rs2_val); end
        checks++; if (bus.iss_rd !== 5'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", bus.iss_rd); end
        checks++; if (bus.iss_reg_write !== 1'b0) begin failures++; $display("FAIL rst_rw got=%b exp=0", bus.iss_reg_write); end
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL rst_dec_ready got=%b exp=1", bus.dec_ready); end
        // reset must win over a presented instruction
        present(32'h10, 1, 2, 32'h55, 32'h66, 0, 3'b000, 0, 0, 0, 0, 7, 1);
        tick();
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL rst_over_accept got=%b exp=0", bus.iss_valid); end
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_add();
        present(32'h40, 1, 2, 32'd5, 32'd7, 0, 3'b000, 0, 0, 0, 0, 3, 1);
        #1;
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL add_dec_ready got=%b exp=1", bus.dec_ready); end
        tick();
        bus.dec_valid = 0;
        #1;
        checks++; if (bus.iss_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", bus.iss_valid); end
        checks++; if (bus.alu_a !== 32'd5) begin failures++; $display("FAIL add_alu_a got=%h exp=5", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd7) begin failures++; $display("FAIL add_alu_b got=%h exp=7", bus.alu_b); end
        checks++; if (bus.alu_control !== 4'b0000) begin failures++; $display("FAIL add_ctrl got=%b exp=0000", bus.alu_control); end
        checks++; if (bus.iss_rd !== 5'd3) begin failures++; $display("FAIL add_rd got=%0d exp=3", bus.iss_rd); end
        checks++; if (bus.iss_reg_write !== 1'b1) begin failures++; $display("FAIL add_rw got=%b exp=1", bus.iss_reg_write); end
        tick();
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL add_consume got=%b exp=0", bus.iss_valid); end
        checks++; if (bus.iss_reg_write !== 1'b0) begin failures++; $display("FAIL add_rw_gate got=%b exp=0", bus.iss_reg_write); end
    endtask

    task automatic test_alu_control();
        present(32'h50, 1, 2, 32'd20, 32'd6, 0, 3'b000, 1, 0, 0, 0, 4, 1);   // SUB
        tick();
        checks++; if (bus.alu_control !== 4'b1000) begin failures++; $display("FAIL sub_ctrl got=%b exp=1000", bus.alu_control); end
        checks++; if (bus.alu_b !== 32'd6) begin failures++; $display("FAIL sub_alu_b got=%h exp=6", bus.alu_b); end
        present(32'h54, 1, 0, 32'd20, 32'd0, 32'hFFFF_FFFF, 3'b000, 1, 1, 0, 0, 4, 1);  // ADDI -1
        tick();
        checks++; if (bus.iss_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.iss_valid); end
        checks++; if (bus.alu_control !== 4'b0000) begin failures++; $display("FAIL addi_ctrl got=%b exp=0000", bus.alu_control); end
        checks++; if (bus.alu_b !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addi_alu_b got=%h exp=ffffffff", bus.alu_b); end
        present(32'h58, 1, 0, 32'd20, 32'd0, 32'h4000_0003, 3'b101, 1, 1, 0, 0, 4, 1);  // SRAI
        tick();
        checks++; if (bus.alu_control !== 4'b1101) begin failures++; $display("FAIL srai_ctrl got=%b exp=1101", bus.alu_control); end
        present(32'h5c, 1, 0, 32'd20, 32'd0, 32'd9, 3'b010, 0, 1, 0, 0, 4, 1);  // SLTI
        tick();
        checks++; if (bus.alu_control !== 4'b1010) begin failures++; $display("FAIL slti_ctrl got=%b exp=1010", bus.alu_control); end
        idle_inputs();
        tick();
    endtask

    task automatic test_forwarding();
        present(32'h60, 3, 0, 32'd1, 32'd0, 0, 3'b000, 0, 0, 0, 0, 4, 1);
        tick();
        bus.dec_valid = 0;
        bus.ex_fwd_en = 1; bus.ex_fwd_rd = 3; bus.ex_fwd_data = 32'd12;
        bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 32'd9;
        #1;
        checks++; if (bus.alu_a !== 32'd12) begin failures++; $display("FAIL fwd_ex_prio got=%h exp=c", bus.alu_a); end
        bus.ex_fwd_en = 0;
        #1;
        checks++; if (bus.alu_a !== 32'd9) begin failures++; $display("FAIL fwd_wb got=%h exp=9", bus.alu_a); end
        bus.ex_fwd_en = 1; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 32'd55;
        bus.wb_fwd_en = 1; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 32'd66;
        #1;
        checks++; if (bus.iss_rs2_val !== 32'd0) begin failures++; $display("FAIL fwd_x0 got=%h exp=0", bus.iss_rs2_val); end
        checks++; if (bus.alu_a !== 32'd1) begin failures++; $display("FAIL fwd_nomatch got=%h exp=1", bus.alu_a); end
        idle_inputs();
        tick();
        // WB result landing in the capture cycle replaces the stale regfile read
        present(32'h64, 5, 6, 32'd100, 32'd7, 0, 3'b000, 0, 0, 0, 0, 8, 1);
        bus.wb_fwd_en = 1; bus.wb_fwd_rd = 5; bus.wb_fwd_data = 32'd200;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.alu_a !== 32'd200) begin failures++; $display("FAIL capture_bypass got=%0d exp=200", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd7) begin failures++; $display("FAIL capture_rs2 got=%0d exp=7", bus.alu_b); end
        tick();
    endtask

    task automatic test_hold_refresh();
        idle_inputs();
        bus.iss_ready = 0;
        present(32'h80, 1, 2, 32'd10, 32'd20, 0, 3'b000, 0, 0, 0, 0, 4, 1);
        tick();
        present(32'h84, 7, 8, 32'd77, 32'd88, 0, 3'b100, 0, 0, 0, 0, 9, 1);
        for (int c = 0; c < 3; c++) begin
            bus.wb_fwd_en = (c == 0); bus.wb_fwd_rd = 2; bus.wb_fwd_data = 32'd44;
            #1;
            checks++; if (bus.dec_ready !== 1'b0) begin failures++; $display("FAIL hold_dec_ready c=%0d got=%b exp=0", c, bus.dec_ready); end
            checks++; if (bus.iss_rd !== 5'd4 || bus.alu_a !== 32'd10) begin failures++; $display("FAIL hold_fields c=%0d rd=%0d a=%0d exp rd=4 a=10", c, bus.iss_rd, bus.alu_a); end
            checks++; if (bus.alu_b !== 32'd44) begin failures++; $display("FAIL hold_refresh c=%0d got=%0d exp=44", c, bus.alu_b); end
            tick();
        end
        bus.wb_fwd_en = 0;
        bus.iss_ready = 1;
        #1;
        checks++; if (bus.iss_rs2_val !== 32'd44) begin failures++; $display("FAIL hold_rs2_val got=%0d exp=44", bus.iss_rs2_val); end
        checks++; if (bus.dec_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", bus.dec_ready); end
        tick();
        checks++; if (bus.iss_rd !== 5'd9 || bus.alu_a !== 32'd77 || bus.alu_control !== 4'b0100) begin failures++; $display("FAIL release_next rd=%0d a=%0d ctrl=%b exp rd=9 a=77 ctrl=0100", bus.iss_rd, bus.alu_a, bus.alu_control); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_reset();
        present(32'h90, 1, 2, 1, 2, 0, 3'b000, 0, 0, 0, 0, 5, 1);
        bus.flush = 1;
        tick();
        idle_inputs();
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL flush_accept got=%b exp=0", bus.iss_valid); end
        present(32'h94, 1, 2, 1, 2, 0, 3'b000, 0, 0, 0, 0, 5, 1);
        tick();
        bus.dec_valid = 0; bus.iss_ready = 0; bus.flush = 1;
        tick();
        bus.flush = 0;
        checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL flush_held got=%b exp=0", bus.iss_valid); end
        present(32'h300, 1, 2, 32'h11, 32'h22, 32'h33, 3'b111, 0, 0, 0, 0, 6, 1);
        bus.iss_ready = 1;
        tick();
        bus.dec_valid = 0; bus.iss_ready = 0;
        tick();
        checks++; if (bus.iss_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_hold got=%b exp=1", bus.iss_valid); end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++; if (bus.iss_valid !== 1'b0 || bus.iss_reg_write !== 1'b0 || bus.iss_rd !== 5'd0) begin failures++; $display("FAIL midhold_rst_ctl v=%b rw=%b rd=%0d exp 0", bus.iss_valid, bus.iss_reg_write, bus.iss_rd); end
        checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.iss_rs2_val !== 32'd0 || bus.alu_control !== 4'd0) begin failures++; $display("FAIL midhold_rst_dat a=%h b=%h s=%h c=%b exp 0", bus.alu_a, bus.alu_b, bus.iss_rs2_val, bus.alu_control); end
        idle_inputs();
        tick();
    endtask

    task automatic test_force_add();
        present(32'h200, 1, 0, 32'h100, 0, 32'd8, 3'b010, 0, 0, 1, 0, 5, 1);   // LW
        tick();
        bus.dec_valid = 0;
        checks++; if (bus.alu_a !== 32'h100 || bus.alu_b !== 32'd8) begin failures++; $display("FAIL lw_ops a=%h b=%h exp a=100 b=8", bus.alu_a, bus.alu_b); end
        checks++; if (bus.alu_control !== 4'b0000) begin failures++; $display("FAIL lw_ctrl got=%b exp=0000", bus.alu_control); end
        present(32'h400, 2, 0, 32'h999, 0, 32'h1000, 3'b000, 0, 0, 1, 1, 6, 1); // AUIPC
        tick();
        bus.dec_valid = 0;
        checks++; if (bus.alu_a !== 32'h400 || bus.alu_b !== 32'h1000) begin failures++; $display("FAIL auipc_ops a=%h b=%h exp a=400 b=1000", bus.alu_a, bus.alu_b); end
        present(32'h404, 1, 3, 32'h10, 32'hABCD, 32'd4, 3'b010, 0, 0, 1, 0, 0, 0); // SW
        tick();
        bus.dec_valid = 0;
        checks++; if (bus.alu_b !== 32'd4 || bus.iss_rs2_val !== 32'hABCD) begin failures++; $display("FAIL sw_ops b=%h st=%h exp b=4 st=abcd", bus.alu_b, bus.iss_rs2_val); end
        idle_inputs();
        tick();
    endtask

    // Behavioural model: one optional held instruction, operands resolved from spec rules.
    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f75, opimm, fadd, apc, rw;
    } instr_t;

    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] held);
        if (idx == 0) return held;
        if (bus.ex_fwd_en && bus.ex_fwd_rd == idx) return bus.ex_fwd_data;
        if (bus.wb_fwd_en && bus.wb_fwd_rd == idx) return bus.wb_fwd_data;
        return held;
    endfunction

    function automatic logic [3:0] expected_ctrl(input instr_t m);
        int alt;
        if (m.fadd) return 4'd0;
        if (m.opimm) alt = (m.f3 == 3'd5 && m.f75) ? 1 : 0;
        else         alt = m.f75 ? 1 : 0;
        if (m.f3 == 3'd2 || m.f3 == 3'd3 || m.f3 == 3'd6 || m.f3 == 3'd7) alt = 1;
        return 4'(int'(m.f3) + 8 * alt);
    endfunction

    task automatic test_random();
        instr_t m;
        bit     m_valid;
        logic [31:0] e_a, e_b, e_s;
        rst_n = 0; idle_inputs(); tick(); rst_n = 1;
        m = '{default: 0};
        m_valid = 0;
        for (int i = 0; i < 600; i++) begin
            bus.dec_valid = ($urandom_range(0, 3) != 0);
            bus.dec_pc = $urandom; bus.dec_imm = $urandom;
            bus.dec_rs1_idx = 5'($urandom_range(0, 3)); bus.dec_rs2_idx = 5'($urandom_range(0, 3));
            bus.dec_rs1_data = $urandom; bus.dec_rs2_data = $urandom;
            bus.dec_funct3 = 3'($urandom); bus.dec_funct7_5 = 1'($urandom);
            bus.dec_op_imm = 1'($urandom); bus.dec_force_add = ($urandom_range(0, 3) == 0);
            bus.dec_a_pc = ($urandom_range(0, 3) == 0); bus.dec_rd = 5'($urandom);
            bus.dec_reg_write = 1'($urandom);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.iss_ready = ($urandom_range(0, 2) != 0);
            bus.ex_fwd_en = 1'($urandom); bus.ex_fwd_rd = 5'($urandom_range(0, 3)); bus.ex_fwd_data = $urandom;
            bus.wb_fwd_en = 1'($urandom); bus.wb_fwd_rd = 5'($urandom_range(0, 3)); bus.wb_fwd_data = $urandom;
            #1;
            e_s = resolve(m.rs2, m.d2);
            e_a = m.apc ? m.pc : resolve(m.rs1, m.d1);
            e_b = (m.opimm || m.fadd) ? m.imm : e_s;
            checks++; if (bus.dec_ready !== (!m_valid || bus.iss_ready)) begin failures++; $display("FAIL rnd_ready i=%0d got=%b", i, bus.dec_ready); end
            checks++; if (bus.iss_valid !== m_valid) begin failures++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, bus.iss_valid, m_valid); end
            checks++; if (bus.iss_reg_write !== (m_valid && m.rw) || bus.iss_rd !== m.rd) begin failures++; $display("FAIL rnd_rd i=%0d rw=%b rd=%0d exp rw=%b rd=%0d", i, bus.iss_reg_write, bus.iss_rd, m_valid && m.rw, m.rd); end
            checks++; if (bus.alu_a !== e_a) begin failures++; $display("FAIL rnd_alu_a i=%0d got=%h exp=%h", i, bus.alu_a, e_a); end
            checks++; if (bus.alu_b !== e_b) begin failures++; $display("FAIL rnd_alu_b i=%0d got=%h exp=%h", i, bus.alu_b, e_b); end
            checks++; if (bus.iss_rs2_val !== e_s) begin failures++; $display("FAIL rnd_rs2 i=%0d got=%h exp=%h", i, bus.iss_rs2_val, e_s); end
            checks++; if (bus.alu_control !== expected_ctrl(m)) begin failures++; $display("FAIL rnd_ctrl i=%0d got=%b exp=%b", i, bus.alu_control, expected_ctrl(m)); end
            @(posedge clk);
            if (bus.flush) begin
                m_valid = 0;
            end else if (bus.dec_valid && (!m_valid || bus.iss_ready)) begin
                m_valid = 1;
                m.pc = bus.dec_pc; m.imm = bus.dec_imm; m.rs1 = bus.dec_rs1_idx; m.rs2 = bus.dec_rs2_idx;
                m.f3 = bus.dec_funct3; m.f75 = bus.dec_funct7_5; m.opimm = bus.dec_op_imm;
                m.fadd = bus.dec_force_add; m.apc = bus.dec_a_pc; m.rd = bus.dec_rd; m.rw = bus.dec_reg_write;
                m.d1 = (bus.wb_fwd_en && bus.wb_fwd_rd == m.rs1 && m.rs1 != 0) ? bus.wb_fwd_data : bus.dec_rs1_data;
                m.d2 = (bus.wb_fwd_en && bus.wb_fwd_rd == m.rs2 && m.rs2 != 0) ? bus.wb_fwd_data : bus.dec_rs2_data;
            end else if (m_valid && bus.iss_ready) begin
                m_valid = 0;
            end else if (m_valid && bus.wb_fwd_en) begin
                if (bus.wb_fwd_rd == m.rs1 && m.rs1 != 0) m.d1 = bus.wb_fwd_data;
                if (bus.wb_fwd_rd == m.rs2 && m.rs2 != 0) m.d2 = bus.wb_fwd_data;
            end
            #1;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_add();
        test_alu_control();
        test_forwarding();
        test_hold_refresh();
        test_flush_reset();
        test_force_add();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
